rd_stream_adapter: RTL and testbench

- Read-side consumer of the async FIFO. Sits downstream of the read-pointer controller and the dual-port memory's synchronous read port.
- Drives `rden` from the controller's `rempty` and a credit check.
- Captures memory read data one cycle after each accepted read into a small circular output buffer.
- Presents the buffered data to the read-domain client as a valid/ready stream.
- Hides the memory's 1-cycle read latency; sustains one word per clock in steady state.

---
 rtl/rd_stream_adapter.sv | 73 +++++++
 tb/tb_rd_stream_adapter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rd_stream_adapter.sv
// Read-side stream adapter: issues credit-limited reads to the FIFO memory and
// buffers the one-cycle-late read data into a small circular valid/ready buffer.
module rd_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rempty,
  output logic                  rden,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  buf_count
);

  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam logic [CNT_WIDTH:0] DEPTH_C  = (CNT_WIDTH + 1)'(BUF_DEPTH);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(BUF_DEPTH - 1);

  // Circular index step; depth need not be a power of two.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [CNT_WIDTH-1:0]  occ;
  logic                  vld_p1;
  logic [CNT_WIDTH:0]    credit_used;
  logic                  acc_p0;
  logic                  pop;

  // Stage p0: read request. Credit counts the in-flight word so a full buffer is never written.
  assign credit_used = {1'b0, occ} + {{CNT_WIDTH{1'b0}}, vld_p1};
  assign rden        = !rempty && (credit_used < DEPTH_C);
  assign acc_p0      = rden;

  assign m_valid   = (occ != '0);
  assign pop       = m_valid && m_ready;
  assign m_data    = buf_mem[rd_idx];
  assign buf_count = occ;

  // Stage p1: rdata is valid while vld_p1 is high and lands in the buffer at the next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      wr_idx <= '0;
      rd_idx <= '0;
      occ    <= '0;
    end else begin
      vld_p1 <= acc_p0;
      if (vld_p1) wr_idx <= next_idx(wr_idx);
      if (pop)    rd_idx <= next_idx(rd_idx);
      case ({vld_p1, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1) buf_mem[wr_idx] <= rdata;
  end

  occ_credit_a: assert property (@(posedge clk) disable iff (!reset_n) credit_used <= DEPTH_C)
    else $error("occupancy plus in-flight exceeds buffer depth");

endmodule

// File: tb/tb_rd_stream_adapter.sv
// Directed bench for rd_stream_adapter with a synchronous-read memory model upstream.
module tb_rd_stream_adapter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rempty;
  logic       rden;
  logic [7:0] rdata;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] buf_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] src [256];
  logic [7:0] src_ptr = 8'd0;
  int         acc_cnt = 0;

  rd_stream_adapter #(.DATA_WIDTH(8), .BUF_DEPTH(3), .CNT_WIDTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .rempty(rempty), .rden(rden), .rdata(rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  // Upstream memory: synchronous read, pointer advances on every accepted read.
  always @(posedge clk) begin
    if (reset_n && rden && !rempty) begin
      rdata   <= src[src_ptr];
      src_ptr <= src_ptr + 8'd1;
      acc_cnt <= acc_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rempty = 1'b1; m_ready = 1'b0;
    repeat (3) next_cycle();
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (buf_count !== 2'd0) begin errors++; $display("FAIL reset_buf_count got %0d want 0", buf_count); end
    checks++; if (rden !== 1'b0) begin errors++; $display("FAIL reset_rden got %b want 0", rden); end
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single();
    src[src_ptr] = 8'hA5;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) next_cycle();
      rempty = (c != 0); m_ready = 1'b1;
      #1;
      checks++;
      if (rden !== (c == 0)) begin errors++; $display("FAIL single_rden c%0d got %b want %b", c, rden, (c == 0)); end
      if (c == 2) begin
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", m_valid); end
        checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", m_data); end
      end
      if (c == 1 || c == 3) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_idle c%0d got %b want 0", c, m_valid); end
      end
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 16; i++) src[src_ptr + 8'(i)] = 8'(i);
    for (int c = 0; c <= 18; c++) begin
      next_cycle();
      rempty = (c >= 16); m_ready = 1'b1;
      #1;
      checks++;
      if (buf_count > 2'd1) begin errors++; $display("FAIL stream_count c%0d got %0d want <=1", c, buf_count); end
      if (c >= 2 && c <= 17) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'(c - 2)) begin
          errors++; $display("FAIL stream_data c%0d got v=%b d=%h want v=1 d=%h", c, m_valid, m_data, 8'(c - 2));
        end
      end
      if (c == 18) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %b want 0", m_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc0;
    for (int i = 0; i < 16; i++) src[src_ptr + 8'(i)] = 8'h40 + 8'(i);
    next_cycle();
    acc0 = acc_cnt;
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) next_cycle();
      rempty = (c >= 12); m_ready = (c >= 7);
      #1;
      if (c >= 3 && c <= 7) begin
        checks++; if (rden !== 1'b0) begin errors++; $display("FAIL bp_rden_stall c%0d got %b want 0", c, rden); end
      end
      if (c >= 4 && c <= 7) begin
        checks++; if (buf_count !== 2'd3) begin errors++; $display("FAIL bp_count c%0d got %0d want 3", c, buf_count); end
      end
      if (c >= 2 && c <= 6) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h40) begin
          errors++; $display("FAIL bp_hold c%0d got v=%b d=%h want v=1 d=40", c, m_valid, m_data);
        end
      end
      if (c == 6) begin
        checks++; if (acc_cnt - acc0 !== 3) begin errors++; $display("FAIL bp_accepts got %0d want 3", acc_cnt - acc0); end
      end
      if (c == 8) begin
        checks++; if (rden !== 1'b1) begin errors++; $display("FAIL bp_resume got %b want 1", rden); end
      end
      if (c >= 7 && c <= 13) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h40 + 8'(c - 7)) begin
          errors++; $display("FAIL bp_drain c%0d got v=%b d=%h want v=1 d=%h", c, m_valid, m_data, 8'h40 + 8'(c - 7));
        end
      end
      if (c >= 14) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_nodup c%0d got %b want 0", c, m_valid); end
      end
    end
  endtask

  task automatic test_wrap();
    int         acc0;
    int         popped = 0;
    int         exp_occ = 0;
    logic       exp_inf = 1'b0;
    logic       last_acc = 1'b0;
    logic       last_pop = 1'b0;
    logic       exp_rden;
    logic [15:0] lfsr = 16'hACE1;
    for (int i = 0; i < 20; i++) src[src_ptr + 8'(i)] = 8'h80 + 8'(i);
    next_cycle();
    acc0 = acc_cnt;
    for (int c = 0; c < 400 && popped < 20; c++) begin
      if (c > 0) next_cycle();
      exp_occ = exp_occ + int'(exp_inf) - int'(last_pop);
      exp_inf = last_acc;
      lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      rempty  = (acc_cnt - acc0 >= 20) || (lfsr[2:0] == 3'd0);
      m_ready = lfsr[5] | lfsr[8];
      #1;
      exp_rden = !rempty && (exp_occ + int'(exp_inf) < 3);
      checks++;
      if (buf_count !== 2'(exp_occ)) begin errors++; $display("FAIL wrap_count c%0d got %0d want %0d", c, buf_count, exp_occ); end
      checks++;
      if (rden !== exp_rden) begin errors++; $display("FAIL wrap_rden c%0d got %b want %b", c, rden, exp_rden); end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 8'h80 + 8'(popped)) begin
          errors++; $display("FAIL wrap_order pop%0d got %h want %h", popped, m_data, 8'h80 + 8'(popped));
        end
        popped++;
      end
      last_acc = rden && !rempty;
      last_pop = m_valid && m_ready;
    end
    checks++;
    if (popped != 20) begin errors++; $display("FAIL wrap_done got %0d pops want 20", popped); end
    rempty = 1'b1; m_ready = 1'b1;
    repeat (4) next_cycle();
  endtask

  task automatic test_empty_race();
    src[src_ptr] = 8'h3C;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) next_cycle();
      rempty = !(c == 0 || c == 7); m_ready = (c >= 5);
      #1;
      if (c >= 1 && c <= 6) begin
        checks++; if (rden !== 1'b0) begin errors++; $display("FAIL race_rden c%0d got %b want 0", c, rden); end
      end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h3C) begin
          errors++; $display("FAIL race_data c%0d got v=%b d=%h want v=1 d=3c", c, m_valid, m_data);
        end
      end
      if (c == 6) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL race_popped got %b want 0", m_valid); end
      end
      if (c == 7) begin
        checks++; if (rden !== 1'b1) begin errors++; $display("FAIL race_resume got %b want 1", rden); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) next_cycle();
      rempty = (c >= 2); m_ready = 1'b0;
    end
    #1;
    checks++; if (buf_count !== 2'd2) begin errors++; $display("FAIL mid_pre_count got %0d want 2", buf_count); end
    reset_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b want 0", m_valid); end
    checks++; if (buf_count !== 2'd0) begin errors++; $display("FAIL mid_async_count got %0d want 0", buf_count); end
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_post_valid got %b want 0", m_valid); end
  endtask

  initial begin
    reset_n = 1'b0; rempty = 1'b1; m_ready = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_wrap();
    test_empty_race();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
